vram_arbiter: RTL and testbench
===============================

Name: vram_arbiter

Overview:
- Schedules the single-port character VRAM between three requesters: video character fetch, host text-write port, and an internal screen-clear engine.
- Sits between the overlay video generator, the host/overlay writer and the VRAM instance, all in the clk_sys domain.
- Video fetch has fixed latency. Host uses a req/ack handshake. Clear uses only otherwise idle cycles.

Parameters:
- AW, 11, VRAM address width; 2^AW character cells.
- DW, 8, VRAM data width.
- FILL_BYTE, 8'h20, value written by the clear engine (space character).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- vid_req  in  1  single-cycle video fetch request
- vid_addr  in  AW  video fetch address, valid with vid_req
- vid_data  out  DW  fetched character
- vid_valid  out  1  vid_data valid, one-cycle pulse
- host_req  in  1  host request, level, held until host_ack
- host_we  in  1  1 = write, 0 = read; stable while host_req is high
- host_addr  in  AW  host address; stable while host_req is high
- host_wdata  in  DW  host write data; stable while host_req is high
- host_ack  out  1  transaction complete, one-cycle pulse
- host_rdata  out  DW  read data, valid with host_ack on reads
- clr_start  in  1  start clear, pulse
- clr_busy  out  1  clear in progress
- ram_addr  out  AW  VRAM address, registered
- ram_we  out  1  VRAM write enable, registered
- ram_wdata  out  DW  VRAM write data, registered
- ram_rdata  in  DW  VRAM read data; synchronous RAM, valid one clock after the address is captured

Behaviour:
- Reset (async, active-high): all outputs 0, including ram_addr/ram_we/ram_wdata. Host outstanding flag, tag pipeline, clear counter and clr_busy are all cleared. No ack or valid is produced for any transaction in flight when reset is applied.
- Arbitration: one grant per clk_sys edge. Fixed priority is video > host > clear.
  - Host is eligible only when host_req=1 and no host transaction is outstanding.
  - Clear is eligible only when clr_busy=1.
- Grant at edge N:
  - ram_addr/ram_we/ram_wdata are registered at edge N.
  - tag1 records the grantee (VID, HRD, HWR, CLR, NONE).
  - At edge N+1, tag2 <= tag1.
  - On a non-grant cycle, ram_we=0 and ram_addr holds its last value.
- Video: vid_req sampled at edge N produces vid_valid=1 and vid_data=ram_rdata at edge N+2. Latency is exactly 2 and is never stalled. Back-to-back vid_req values are all served, which starves host and clear for that period.
- Host write granted at edge N: ram_we=1 for one cycle; host_ack pulses at edge N+1.
- Host read granted at edge N: host_ack and host_rdata are registered at edge N+2.
- Host outstanding flag: set at the grant edge, cleared at the ack edge. host_req sampled on the edge after the ack is treated as a new transaction, so the earliest re-grant is ack edge + 1.
- Clear engine, states IDLE/RUN:
  - clr_start in IDLE: go to RUN, counter=0, clr_busy=1 at the next edge.
  - Each CLR grant writes FILL_BYTE at the counter address and increments the counter.
  - The grant that writes address 2^AW-1 returns the engine to IDLE; clr_busy=0 on the same edge.
  - clr_start while in RUN restarts at counter=0.
  - clr_start coincident with the final write: the restart wins.
- Host writes during a clear are permitted. A cell not yet reached by the clear will be overwritten with FILL_BYTE.
- Address arithmetic is modulo 2^AW. The counter has no wrap beyond the final cell.

Optional Feature:
- Macro: VRAM_ARB_CLEAR_EN.
- Defined: clear engine present as specified.
- Undefined: no clear logic; clr_start is ignored, clr_busy is tied 0, and the arbiter has only the VID and HOST grantees.

Test Plan:
1. RAM[0x005]=0x41; vid_req with vid_addr=0x005 at edge 10 -> ram_addr=0x005 after edge 10; vid_valid=1, vid_data=0x41 at edge 12 only.
2. Host write addr 0x010 data 0x7E granted at edge 20 -> one cycle with ram_we=1, ram_addr=0x010, ram_wdata=0x7E; host_ack at edge 21. Then a host read of 0x010 -> host_rdata=0x7E with host_ack 2 edges after its grant.
3. vid_req and host_req (read) sampled at the same edge 30 -> video granted at 30; host granted at 31, ack at 33; vid_valid at 32.
4. AW=4, clr_start, no other traffic -> 16 consecutive writes of 0x20 to addresses 0..15; clr_busy high for exactly 16 cycles. Repeat with vid_req every 3rd cycle -> still 16 writes, 0 skipped addresses, completion delayed by the video slots.
5. clr_start at counter=7 -> next clear write targets address 0; 16 further writes follow.
6. Reset asserted during a host read (between grant and ack) and mid-clear -> all outputs 0 immediately; after release no host_ack, clr_busy=0, ram_we=0 until a new request.

Source files
------------

// File: rtl/vram_arbiter.sv
// +--------------------------------------------------------------------------+
// | vram_arbiter: single-port character VRAM scheduler for video fetch,      |
// | host text access and screen clear. Clear engine: VRAM_ARB_CLEAR_EN.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module vram_arbiter #(
    parameter int              AW        = 11,
    parameter int              DW        = 8,
    parameter logic [DW-1:0]   FILL_BYTE = 8'h20
) (
    input  logic          clk_sys,
    input  logic          reset,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    typedef enum logic [2:0] {
        TAG_NONE = 3'd0,
        TAG_VID  = 3'd1,
        TAG_HRD  = 3'd2,
        TAG_HWR  = 3'd3,
        TAG_CLR  = 3'd4
    } tag_t;

    tag_t          w_grant;
    tag_t          r_tag1;
    tag_t          r_tag2;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_host_done;
    logic          r_host_out;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_we;
    logic [DW-1:0] r_ram_wdata;
    logic          r_vid_valid;
    logic [DW-1:0] r_vid_data;
    logic          r_host_ack;
    logic [DW-1:0] r_host_rdata;

`ifdef VRAM_ARB_CLEAR_EN
    typedef enum logic [0:0] {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    clr_state_t    r_clr_state;
    clr_state_t    w_clr_state_nxt;
    logic [AW-1:0] r_clr_cnt;
    logic [AW-1:0] w_clr_cnt_nxt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_clr_state <= CLR_IDLE;
            r_clr_cnt   <= '0;
        end else begin
            r_clr_state <= w_clr_state_nxt;
            r_clr_cnt   <= w_clr_cnt_nxt;
        end
    end

    // A start pulse always restarts from cell 0, even on the final write.
    always_comb begin
        w_clr_state_nxt = r_clr_state;
        w_clr_cnt_nxt   = r_clr_cnt;
        if (clr_start) begin
            w_clr_state_nxt = CLR_RUN;
            w_clr_cnt_nxt   = '0;
        end else if (r_clr_state == CLR_RUN && w_grant == TAG_CLR) begin
            w_clr_cnt_nxt = r_clr_cnt + AW'(1);
            if (r_clr_cnt == '1) begin
                w_clr_state_nxt = CLR_IDLE;
            end
        end
    end

    assign clr_busy = (r_clr_state == CLR_RUN);
`else
    logic w_unused_clr;
    assign w_unused_clr = &{1'b0, clr_start, FILL_BYTE};
    assign clr_busy     = 1'b0;
`endif

    // Fixed priority: video, then host (if none outstanding), then clear.
    always_comb begin
        w_grant = TAG_NONE;
        w_addr  = r_ram_addr;
        w_wdata = r_ram_wdata;
        if (vid_req) begin
            w_grant = TAG_VID;
            w_addr  = vid_addr;
        end else if (host_req && !r_host_out) begin
            w_grant = host_we ? TAG_HWR : TAG_HRD;
            w_addr  = host_addr;
            w_wdata = host_wdata;
        end
`ifdef VRAM_ARB_CLEAR_EN
        else if (clr_busy) begin
            w_grant = TAG_CLR;
            w_addr  = r_clr_cnt;
            w_wdata = FILL_BYTE;
        end
`endif
    end

    assign w_host_done = (r_tag1 == TAG_HWR) || (r_tag2 == TAG_HRD);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_wdata  <= '0;
            r_tag1       <= TAG_NONE;
            r_tag2       <= TAG_NONE;
            r_vid_valid  <= 1'b0;
            r_vid_data   <= '0;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
            r_host_out   <= 1'b0;
        end else begin
            r_ram_addr  <= w_addr;
            r_ram_we    <= (w_grant == TAG_HWR) || (w_grant == TAG_CLR);
            r_ram_wdata <= w_wdata;
            r_tag1      <= w_grant;
            r_tag2      <= r_tag1;
            r_vid_valid <= (r_tag2 == TAG_VID);
            if (r_tag2 == TAG_VID) begin
                r_vid_data <= ram_rdata;
            end
            r_host_ack <= w_host_done;
            if (r_tag2 == TAG_HRD) begin
                r_host_rdata <= ram_rdata;
            end
            if (w_grant == TAG_HWR || w_grant == TAG_HRD) begin
                r_host_out <= 1'b1;
            end else if (w_host_done) begin
                r_host_out <= 1'b0;
            end
        end
    end

    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;
    assign vid_valid  = r_vid_valid;
    assign vid_data   = r_vid_data;
    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rdata;

endmodule

`default_nettype wire

// File: tb/tb_vram_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_vram_arbiter: directed bench for vram_arbiter with a sync RAM model.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_vram_arbiter;

    localparam int AW = 4;
    localparam int DW = 8;

    logic          clk_sys = 1'b0;
    logic          reset;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          clr_start;
    logic          clr_busy;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int n_vec = 0;
    int n_err = 0;
    int busy_cnt;
    int wr_cnt;

    vram_arbiter #(.AW(AW), .DW(DW), .FILL_BYTE(8'h20)) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .vid_req    (vid_req),
        .vid_addr   (vid_addr),
        .vid_data   (vid_data),
        .vid_valid  (vid_valid),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    always #5 clk_sys = ~clk_sys;

    // Synchronous single-port RAM, read-before-write.
    always @(posedge clk_sys) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ram_addr"},  ram_addr,  0);
        chk({tag, "_ram_we"},    ram_we,    0);
        chk({tag, "_ram_wdata"}, ram_wdata, 0);
        chk({tag, "_vid_valid"}, vid_valid, 0);
        chk({tag, "_vid_data"},  vid_data,  0);
        chk({tag, "_host_ack"},  host_ack,  0);
        chk({tag, "_host_rdata"}, host_rdata, 0);
        chk({tag, "_clr_busy"},  clr_busy,  0);
    endtask

    // Follows a running clear to completion, checking each write in order.
    task automatic follow_clear(input bit with_vid, output int busy, output int wr);
        busy = 0;
        wr   = 0;
        for (int i = 0; i < 80; i++) begin
            if (!clr_busy) break;
            busy++;
            vid_req  = with_vid && (i % 3 == 0);
            vid_addr = 4'h5;
            tick();
            if (ram_we) begin
                chk("clr_addr",  ram_addr,  wr[AW-1:0]);
                chk("clr_wdata", ram_wdata, 8'h20);
                wr++;
            end
        end
        vid_req = 1'b0;
    endtask

    initial begin
        reset = 1'b1; vid_req = 1'b0; vid_addr = '0;
        host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
        clr_start = 1'b0;
        #2;
        chk_all_zero("reset");
        tick(); tick();
        reset = 1'b0;
        tick();

        // Preload cell 5 through the host port.
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'h5; host_wdata = 8'h41;
        tick();
        chk("pre_we", ram_we, 1);
        tick();
        chk("pre_ack", host_ack, 1);
        host_req = 1'b0;
        tick();

        // Video fetch: grant at N, data at N+2 only.
        vid_req = 1'b1; vid_addr = 4'h5;
        tick();
        chk("vid_ram_addr", ram_addr, 4'h5);
        chk("vid_ram_we", ram_we, 0);
        vid_req = 1'b0;
        tick();
        chk("vid_valid_n1", vid_valid, 0);
        tick();
        chk("vid_valid_n2", vid_valid, 1);
        chk("vid_data_n2", vid_data, 8'h41);
        tick();
        chk("vid_valid_n3", vid_valid, 0);

        // Host write: we for one cycle, ack one edge later, no regrant at ack edge.
        host_req = 1'b1; host_we = 1'b1; host_addr = 4'hA; host_wdata = 8'h7E;
        tick();
        chk("hwr_we", ram_we, 1);
        chk("hwr_addr", ram_addr, 4'hA);
        chk("hwr_wdata", ram_wdata, 8'h7E);
        chk("hwr_ack_n0", host_ack, 0);
        tick();
        chk("hwr_ack_n1", host_ack, 1);
        chk("hwr_we_n1", ram_we, 0);

        // Host read of the same cell: ack two edges after grant.
        host_we = 1'b0; host_wdata = 8'h00;
        tick();
        chk("hrd_addr", ram_addr, 4'hA);
        chk("hrd_we", ram_we, 0);
        chk("hrd_ack_n0", host_ack, 0);
        tick();
        chk("hrd_ack_n1", host_ack, 0);
        tick();
        chk("hrd_ack_n2", host_ack, 1);
        chk("hrd_rdata", host_rdata, 8'h7E);
        host_req = 1'b0;
        tick();
        chk("hrd_ack_n3", host_ack, 0);

        // Simultaneous video and host read: video first, host one edge later.
        vid_req = 1'b1; vid_addr = 4'h5;
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'hA;
        tick();
        chk("col_vid_addr", ram_addr, 4'h5);
        vid_req = 1'b0;
        tick();
        chk("col_host_addr", ram_addr, 4'hA);
        chk("col_vid_valid_n1", vid_valid, 0);
        tick();
        chk("col_vid_valid", vid_valid, 1);
        chk("col_vid_data", vid_data, 8'h41);
        chk("col_host_ack_n2", host_ack, 0);
        tick();
        chk("col_host_ack", host_ack, 1);
        chk("col_host_rdata", host_rdata, 8'h7E);
        host_req = 1'b0;
        tick();

`ifdef VRAM_ARB_CLEAR_EN
        // Plain clear: 16 writes, busy for exactly 16 cycles.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        chk("clr_busy_on", clr_busy, 1);
        follow_clear(1'b0, busy_cnt, wr_cnt);
        chk("clr_busy_cycles", busy_cnt, 16);
        chk("clr_writes", wr_cnt, 16);
        chk("clr_busy_off", clr_busy, 0);

        // Clear interleaved with video every third cycle.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        follow_clear(1'b1, busy_cnt, wr_cnt);
        chk("clrv_writes", wr_cnt, 16);
        chk("clrv_busy_cycles", busy_cnt, 24);
        chk("clrv_busy_off", clr_busy, 0);
        tick(); tick();

        // Restart at counter 7: the write of 7 lands, then 16 writes from 0.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ram_we && ram_addr == 4'h6) break;
        end
        chk("rst_seen6", ram_addr, 4'h6);
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        chk("rst_addr7", ram_addr, 4'h7);
        chk("rst_busy", clr_busy, 1);
        follow_clear(1'b0, busy_cnt, wr_cnt);
        chk("rst_writes", wr_cnt, 16);
        chk("rst_busy_off", clr_busy, 0);

        // Start a clear so reset lands mid-clear.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        tick(); tick();
`else
        // Without the clear engine, clr_start has no effect.
        clr_start = 1'b1;
        tick();
        clr_start = 1'b0;
        chk("noclr_busy", clr_busy, 0);
        chk("noclr_we", ram_we, 0);
        tick();
        chk("noclr_busy2", clr_busy, 0);
        chk("noclr_we2", ram_we, 0);
`endif

        // Reset between host read grant and ack.
        host_req = 1'b1; host_we = 1'b0; host_addr = 4'h3;
        tick();
        chk("rr_grant_addr", ram_addr, 4'h3);
        reset = 1'b1;
        #1;
        chk_all_zero("async_rst");
        host_req = 1'b0;
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("post_rst_ack", host_ack, 0);
            chk("post_rst_we", ram_we, 0);
            chk("post_rst_busy", clr_busy, 0);
            chk("post_rst_valid", vid_valid, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
